// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronizer, frame deserializer, byte FIFO
// and make/break decoder producing {key_count, scan_code}.
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        pause,
  output logic [15:0] data,
  output logic        key_down,
  output logic        frame_err,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BREAK = 1'b1;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];

  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tcnt;
  logic          last_bit;
  logic          frame_good;
  logic          push;
  logic          bad_frame;
  logic          timeout;

  // frame[0] is start, [8:1] data, [9] parity, [10] stop on the 11th edge
  assign frame      = {dat_sync[1], shreg};
  assign last_bit   = fall && (bit_cnt == 4'd10);
  assign frame_good = (frame[0] == 1'b0) && frame[10] && (^frame[9:1]);
  assign push       = last_bit & frame_good;
  assign bad_frame  = last_bit & ~frame_good;
  assign timeout    = (bit_cnt != 4'd0) && !fall && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= 4'd0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_frame | timeout;
      if (fall) begin
        shreg   <= frame[10:1];
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        tcnt    <= '0;
      end else if (bit_cnt != 4'd0) begin
        if (timeout) begin
          bit_cnt <= 4'd0;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic [7:0]  rd_byte;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && !pause;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= frame[8:1];
  end

  assign rd_byte = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  logic [0:0] state;
  logic [7:0] scan_code;
  logic [7:0] key_count;
  logic       is_brk;
  logic       is_ext;

  assign is_brk = (rd_byte == BRK_CODE);
  assign is_ext = (rd_byte == EXT_CODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scan_code <= 8'h00;
      key_count <= 8'h00;
      key_down  <= 1'b0;
    end else if (pop) begin
      if (state == IDLE) begin
        unique case (1'b1)
          is_brk: state <= BREAK;
          is_ext: state <= IDLE;
          default: begin
            if (!key_down || rd_byte != scan_code)
              key_count <= key_count + 8'd1;
            scan_code <= rd_byte;
            key_down  <= 1'b1;
          end
        endcase
      end else begin
        if (!is_ext) begin
          if (rd_byte == scan_code) key_down <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

  assign data = {key_count, scan_code};

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Randomized and directed bench for ps2_kbd_decoder against a
// byte-level behavioural model of the keyboard protocol.
module tb_ps2_kbd_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        pause;
  logic [15:0] data;
  logic        key_down;
  logic        frame_err;
  logic        overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int err_cnt  = 0;

  ps2_kbd_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .pause    (pause),
    .data     (data),
    .key_down (key_down),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

  logic       m_brk;
  logic [7:0] m_scan;
  logic [7:0] m_cnt;
  logic       m_down;
  logic       m_ovf;
  logic [7:0] q[$];

  function automatic void m_reset();
    m_brk = 0; m_scan = 0; m_cnt = 0; m_down = 0; m_ovf = 0;
    q.delete();
  endfunction

  function automatic void m_decode(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (m_brk) begin
      if (b == m_scan) m_down = 0;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_down || b != m_scan) m_cnt = m_cnt + 8'd1;
      m_scan = b;
      m_down = 1;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad,
                           input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(b, bad, 11);
    repeat (8) @(posedge clk);
    #1;
    if (!bad) begin
      if (pause) begin
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1;
      end else begin
        m_decode(b);
      end
    end
  endtask

  task automatic test_reset();
    int e0;
    chk_cnt++;
    if (data !== 16'h0000) $display("FAIL rst_data got %h want 0000", data);
    else pass_cnt++;
    chk_cnt++;
    if (key_down !== 1'b0) $display("FAIL rst_key_down got %b want 0", key_down);
    else pass_cnt++;
    chk_cnt++;
    if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err);
    else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow);
    else pass_cnt++;
    do_reset();
    e0 = err_cnt;
    send_bits(8'h1C, 0, 10);
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (data !== 16'h0000) $display("FAIL early_data got %h want 0000", data);
    else pass_cnt++;
    @(posedge clk);
    #1;
    m_decode(8'h1C);
    chk_cnt++;
    if (data !== {m_cnt, m_scan})
      $display("FAIL e2_data got %h want %h", data, {m_cnt, m_scan});
    else pass_cnt++;
    chk_cnt++;
    if (key_down !== 1'b1) $display("FAIL e2_key_down got %b want 1", key_down);
    else pass_cnt++;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++;
    if (err_cnt - e0 != 0)
      $display("FAIL good_frame_err got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_typematic();
    logic [7:0] seq [5];
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    do_reset();
    foreach (seq[i]) begin
      send_frame(seq[i], 0);
      chk_cnt++;
      if (data !== {m_cnt, m_scan})
        $display("FAIL typ_data[%0d] got %h want %h", i, data, {m_cnt, m_scan});
      else pass_cnt++;
      chk_cnt++;
      if (key_down !== m_down)
        $display("FAIL typ_key_down[%0d] got %b want %b", i, key_down, m_down);
      else pass_cnt++;
    end
    send_frame(8'h32, 0);
    chk_cnt++;
    if (data !== 16'h0232) $display("FAIL typ_next got %h want 0232", data);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_frame(8'h1C, 1);
    chk_cnt++;
    if (err_cnt - e0 != 1)
      $display("FAIL par_err got %0d cycles want 1", err_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (data !== {m_cnt, m_scan})
      $display("FAIL par_data got %h want %h", data, {m_cnt, m_scan});
    else pass_cnt++;
    send_frame(8'h1B, 0);
    chk_cnt++;
    if (data !== 16'h011B) $display("FAIL par_next got %h want 011B", data);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    pause = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'h15 + 8'(i), 0);
      if (i >= DEPTH - 1) begin
        chk_cnt++;
        if (overflow !== m_ovf)
          $display("FAIL ovf_flag[%0d] got %b want %b", i, overflow, m_ovf);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (data !== 16'h0000) $display("FAIL ovf_paused got %h want 0000", data);
    else pass_cnt++;
    pause = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      m_decode(q.pop_front());
      chk_cnt++;
      if (data !== {m_cnt, m_scan})
        $display("FAIL drain[%0d] got %h want %h", k, data, {m_cnt, m_scan});
      else pass_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (data !== {m_cnt, m_scan})
      $display("FAIL drain_end got %h want %h", data, {m_cnt, m_scan});
    else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_bits(8'h5A, 0, 5);
    repeat (TMO - 20) @(posedge clk);
    #1;
    chk_cnt++;
    if (err_cnt - e0 != 0)
      $display("FAIL tmo_early got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
    repeat (70) @(posedge clk);
    #1;
    chk_cnt++;
    if (err_cnt - e0 != 1)
      $display("FAIL tmo_pulse got %0d pulses want 1", err_cnt - e0);
    else pass_cnt++;
    send_frame(8'h24, 0);
    chk_cnt++;
    if (data !== 16'h0124) $display("FAIL tmo_next got %h want 0124", data);
    else pass_cnt++;
  endtask

  task automatic test_rst_midframe();
    send_frame(8'h2B, 0);
    send_bits(8'h33, 0, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({data, key_down, overflow} !== 18'h0)
      $display("FAIL mid_rst got %h/%b/%b want 0", data, key_down, overflow);
    else pass_cnt++;
    rst = 1'b0;
    m_reset();
    repeat (6) @(posedge clk);
    #1;
    chk_cnt++;
    if (data !== 16'h0000) $display("FAIL mid_empty got %h want 0000", data);
    else pass_cnt++;
    send_frame(8'h1C, 0);
    chk_cnt++;
    if (data !== 16'h011C) $display("FAIL mid_next got %h want 011C", data);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    bit bad;
    int e0;
    pool = '{8'hF0, 8'hE0, 8'h1C, 8'h1B, 8'h32, 8'h15, 8'h24, 8'h00};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b = pool[$urandom_range(0, 7)];
      if (b == 8'h00) b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      e0 = err_cnt;
      send_frame(b, bad);
      chk_cnt++;
      if (data !== {m_cnt, m_scan} || key_down !== m_down)
        $display("FAIL rnd[%0d] byte %h got %h/%b want %h/%b", i, b,
                 data, key_down, {m_cnt, m_scan}, m_down);
      else pass_cnt++;
      chk_cnt++;
      if (err_cnt - e0 != int'(bad))
        $display("FAIL rnd_err[%0d] got %0d want %0d", i, err_cnt - e0, bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(i[0] ? 8'h1B : 8'h1C, 0);
      if (i == 254) begin
        chk_cnt++;
        if (data[15:8] !== 8'hFF)
          $display("FAIL wrap_ff got %h want FF", data[15:8]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (data !== {m_cnt, m_scan} || data[15:8] !== 8'h00)
      $display("FAIL wrap_00 got %h want %h", data, {m_cnt, m_scan});
    else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    pause    = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_typematic();
    test_parity();
    test_overflow();
    test_timeout();
    test_rst_midframe();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
